vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator: the next generation of the fixed-mode `vga` controller. Produces hsync/vsync/composite sync/blank for any resolution set by parameters, drives 4 selectable test patterns on R/G/B, and cycles patterns on a debounced push-button. The pattern switch is applied only at frame boundaries. It sits between the board button/pixel clock and the video DAC, and is the bring-up source for new display modes.

---
 rtl/vga_pattern_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Parametrised VGA timing and test-pattern generator. Counts pixels and lines
// for the mode set by the parameters, produces registered syncs, blanking and
// a frame-start pulse, and paints one of four test patterns. A debounced
// push-button steps the pattern; the change takes effect at a frame boundary.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous reset, active-low
//   boton        raw push-button, active-high, asynchronous to clk
//   R, G, B      pixel colour, COLOR_W bits each, zero outside the visible area
//   hsync/vsync  sync pulses, level SYNC_POL during the pulse
//   sync_b       composite sync, low while either pulse is active
//   blank_b      high only in the visible area
//   frame_start  one-cycle pulse with the first visible pixel of a frame
//   pattern      pattern currently displayed
module vga_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_POL        = 0,
    parameter int COLOR_W         = 8,
    parameter int CHK_LOG2        = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               boton,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               hsync,
    output logic               vsync,
    output logic               sync_b,
    output logic               blank_b,
    output logic               frame_start,
    output logic [1:0]         pattern
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES);

    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0]  BAR_LAST = BW'(BAR_LEN - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic           SYNC_ON  = 1'(SYNC_POL);
    localparam logic           SYNC_OFF = ~SYNC_ON;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_WHITE    = 2'd3
    } pattern_e;

    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [BW-1:0]  bar_sub;
    logic [2:0]     bar;
    logic           btn_meta, btn_sync, db_level;
    logic [DBW-1:0] db_cnt;
    logic           pending;
    pattern_e       sel;

    logic h_wrap, frame_end, db_accept, db_rise;
    assign h_wrap    = (h_cnt == H_LAST);
    assign frame_end = h_wrap && (v_cnt == V_LAST);
    // The debounced level flips on the Nth consecutive cycle at the new level.
    assign db_accept = (btn_sync != db_level) && (db_cnt == DB_LAST);
    assign db_rise   = db_accept && btn_sync;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // bar tracks h_cnt / BAR_LEN across the visible part of the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_sub <= '0;
            bar     <= '0;
        end else if (h_wrap) begin
            bar_sub <= '0;
            bar     <= '0;
        end else if (h_cnt < H_VIS) begin
            if (bar_sub == BAR_LAST) begin
                bar_sub <= '0;
                bar     <= bar + 1'b1;
            end else begin
                bar_sub <= bar_sub + 1'b1;
            end
        end
    end

    // Button synchroniser and debouncer; the counter restarts whenever the
    // synchronised level falls back to the accepted one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= boton;
            btn_sync <= btn_meta;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_accept) begin
                db_level <= btn_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Presses collapse into one pending request per frame. An edge landing on
    // the update cycle itself re-arms pending for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel     <= PAT_BARS;
            pending <= 1'b0;
        end else if (frame_end && pending) begin
            sel     <= pattern_e'(sel + 2'd1);
            pending <= db_rise;
        end else if (db_rise) begin
            pending <= 1'b1;
        end
    end

    logic               visible, hs_act, vs_act;
    logic [COLOR_W-1:0] r_n, g_n, b_n;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_act  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_act  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        r_n     = '0;
        g_n     = '0;
        b_n     = '0;
        case (sel)
            PAT_BARS: begin
                r_n = {COLOR_W{bar[2]}};
                g_n = {COLOR_W{bar[1]}};
                b_n = {COLOR_W{bar[0]}};
            end
            PAT_CHECKER: begin
                r_n = {COLOR_W{h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]}};
                g_n = r_n;
                b_n = r_n;
            end
            PAT_GRADIENT: begin
                r_n = COLOR_W'(h_cnt);
                g_n = r_n;
                b_n = r_n;
            end
            PAT_WHITE: begin
                r_n = '1;
                g_n = '1;
                b_n = '1;
            end
            default: ;
        endcase
        if (!visible) begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
        end
    end

    // One register stage for every output keeps colour and timing aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            frame_start <= 1'b0;
            pattern     <= 2'd0;
        end else begin
            R           <= r_n;
            G           <= g_n;
            B           <= b_n;
            hsync       <= hs_act ? SYNC_ON : SYNC_OFF;
            vsync       <= vs_act ? SYNC_ON : SYNC_OFF;
            sync_b      <= ~(hs_act | vs_act);
            blank_b     <= visible;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            pattern     <= sel;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

    // Small mode for the main instance.
    localparam int HA = 8, HF = 2, HSW = 2, HB = 2, HT = HA + HF + HSW + HB;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1, VT = VA + VF + VSW + VB;
    localparam int CHK = 1, DB = 4;
    // Second instance: positive syncs, different mode.
    localparam int HA2 = 16, HF2 = 2, HSW2 = 5, HB2 = 1, HT2 = HA2 + HF2 + HSW2 + HB2;
    localparam int VA2 = 6, VF2 = 1, VSW2 = 2, VB2 = 1, VT2 = VA2 + VF2 + VSW2 + VB2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic boton = 1'b0;
    logic zero_btn = 1'b0;

    logic [7:0] r, g, b;
    logic       hsync, vsync, sync_b, blank_b, frame_start;
    logic [1:0] pattern;
    logic [7:0] r2, g2, b2;
    logic       hsync2, vsync2, sync_b2, blank_b2, frame_start2;
    logic [1:0] pattern2;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(0), .COLOR_W(8), .CHK_LOG2(CHK), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .boton(boton),
        .R(r), .G(g), .B(b),
        .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
        .frame_start(frame_start), .pattern(pattern)
    );

    vga_pattern_gen #(
        .H_ACTIVE(HA2), .H_FP(HF2), .H_SYNC(HSW2), .H_BP(HB2),
        .V_ACTIVE(VA2), .V_FP(VF2), .V_SYNC(VSW2), .V_BP(VB2),
        .SYNC_POL(1), .COLOR_W(8), .CHK_LOG2(2), .DEBOUNCE_CYCLES(DB)
    ) dut_pos (
        .clk(clk), .reset(reset), .boton(zero_btn),
        .R(r2), .G(g2), .B(b2),
        .hsync(hsync2), .vsync(vsync2), .sync_b(sync_b2), .blank_b(blank_b2),
        .frame_start(frame_start2), .pattern(pattern2)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [3:0] syn;   // {hsync, vsync, sync_b, blank_b}
        logic       fs;
        logic [1:0] pat;
    } obs_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    obs_t exp_o;
    logic [3:0] exp2;

    // Reference model state: screen position, selected pattern, pending press,
    // accepted button level and the button samples on their way through.
    int mx, my, m2x, m2y, msel;
    bit mpend, mdb, h1, h2;
    bit win[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [3:0] sync_bits(input int x, input int y,
                                             input int ha, input int hf, input int hsw,
                                             input int va, input int vf, input int vsw,
                                             input logic pol);
        logic hs_on, vs_on, vis;
        hs_on = (x >= ha + hf) && (x < ha + hf + hsw);
        vs_on = (y >= va + vf) && (y < va + vf + vsw);
        vis   = (x < ha) && (y < va);
        return {hs_on ? pol : ~pol, vs_on ? pol : ~pol, ~(hs_on | vs_on), vis};
    endfunction

    function automatic obs_t expect_px(input int x, input int y, input int sel);
        obs_t       o;
        int         bar;
        logic [7:0] c;
        o.syn = sync_bits(x, y, HA, HF, HSW, VA, VF, VSW, 1'b0);
        o.fs  = (x == 0) && (y == 0);
        o.pat = 2'(sel);
        case (sel)
            0: begin
                bar = x / (HA / 8);
                o.r = ((bar / 4) % 2 == 1) ? 8'hFF : 8'h00;
                o.g = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
                o.b = (bar % 2 == 1) ? 8'hFF : 8'h00;
            end
            1: begin
                c = ((((x >> CHK) ^ (y >> CHK)) & 1) == 1) ? 8'hFF : 8'h00;
                o.r = c; o.g = c; o.b = c;
            end
            2: begin
                c = 8'(x % 256);
                o.r = c; o.g = c; o.b = c;
            end
            default: begin
                o.r = 8'hFF; o.g = 8'hFF; o.b = 8'hFF;
            end
        endcase
        if (!((x < HA) && (y < VA))) begin
            o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
        end
        return o;
    endfunction

    // Called once per rising edge: predicts the outputs that edge registers
    // and moves the model on by one pixel.
    function automatic void model_edge();
        bit lvl, rise, same;
        if (!reset) begin
            mx = 0; my = 0; m2x = 0; m2y = 0; msel = 0;
            mpend = 0; mdb = 0; h1 = 0; h2 = 0;
            win.delete();
            exp_o = {8'h00, 8'h00, 8'h00, 4'b1110, 1'b0, 2'd0};
            exp2  = 4'b0010;
            return;
        end
        exp_o = expect_px(mx, my, msel);
        exp2  = sync_bits(m2x, m2y, HA2, HF2, HSW2, VA2, VF2, VSW2, 1'b1);
        // Button seen two edges late; accepted once DB samples in a row agree.
        lvl = h2;
        h2  = h1;
        h1  = boton;
        win.push_back(lvl);
        if (win.size() > DB) void'(win.pop_front());
        same = 1;
        foreach (win[i]) if (win[i] != lvl) same = 0;
        rise = 0;
        if (win.size() == DB && same && lvl != mdb) begin
            mdb  = lvl;
            rise = lvl;
        end
        if (mx == HT - 1 && my == VT - 1 && mpend) begin
            msel  = (msel + 1) % 4;
            mpend = rise;
        end else begin
            mpend = mpend | rise;
        end
        mx = mx + 1;
        if (mx == HT) begin mx = 0; my = (my + 1) % VT; end
        m2x = m2x + 1;
        if (m2x == HT2) begin m2x = 0; m2y = (m2y + 1) % VT2; end
    endfunction

    task automatic step();
        obs_t obs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        obs = {r, g, b, hsync, vsync, sync_b, blank_b, frame_start, pattern};
        check("px", 32'(obs), 32'(exp_o));
        check("sync_pos", 32'({hsync2, vsync2, sync_b2, blank_b2}), 32'(exp2));
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!exp_o.fs && n < 300);
        check("fs_reached", 32'(frame_start), 32'd1);
    endtask

    task automatic press(input int len);
        boton = 1'b1;
        repeat (len) step();
        boton = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] bars_tab [8];
        logic [23:0] chk_tab  [8];
        int hs_low, vs_low, bl_hi, fs_first, fs_gap, hs2_hi, vs2_hi, sb2_low;

        bars_tab = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                     24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        chk_tab  = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                     24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};

        // Reset held for 5 cycles.
        reset = 1'b0;
        boton = 1'b0;
        repeat (5) step();
        check("rst_pattern", 32'(pattern), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_blank", 32'(blank_b), 32'd0);
        check("rst_sync_b", 32'(sync_b), 32'd1);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_hsync_pos", 32'(hsync2), 32'd0);

        // Frame timing: 2 small frames, 2 frames of the positive-sync mode.
        reset = 1'b1;
        hs_low = 0; vs_low = 0; bl_hi = 0; fs_first = -1; fs_gap = -1;
        hs2_hi = 0; vs2_hi = 0; sb2_low = 0;
        for (int i = 0; i < 2 * HT2 * VT2; i++) begin
            step();
            if (i < 2 * HT * VT) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
                if (blank_b) bl_hi++;
                if (frame_start) begin
                    if (fs_first < 0) fs_first = i;
                    else if (fs_gap < 0) fs_gap = i - fs_first;
                end
            end
            if (hsync2) hs2_hi++;
            if (vsync2) vs2_hi++;
            if (!sync_b2) sb2_low++;
        end
        check("fs_first", 32'(fs_first), 32'd0);
        check("fs_period", 32'(fs_gap), 32'd98);
        check("hsync_low_cnt", 32'(hs_low), 32'd28);
        check("vsync_low_cnt", 32'(vs_low), 32'd28);
        check("blank_hi_cnt", 32'(bl_hi), 32'd64);
        check("hsync_pos_cnt", 32'(hs2_hi), 32'd100);
        check("vsync_pos_cnt", 32'(vs2_hi), 32'd96);
        check("sync_b_pos_cnt", 32'(sb2_low), 32'd176);

        // Colour bars on line 0.
        wait_fs();
        for (int x = 0; x < 8; x++) begin
            check("bars", 32'({r, g, b}), 32'(bars_tab[x]));
            step();
        end

        // Button press mid-frame: applied at the next frame start.
        repeat (30) step();
        press(10);
        check("pat_before_fs", 32'(pattern), 32'd0);
        wait_fs();
        check("pat_after_press", 32'(pattern), 32'd1);
        for (int x = 0; x < 8; x++) begin
            check("checker", 32'({r, g, b}), 32'(chk_tab[x]));
            step();
        end

        // Three more presses at random points with random lengths.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 97)) step();
            press(int'($urandom_range(6, 20)));
            wait_fs();
            wait_fs();
            check("pat_cycle", 32'(pattern), 32'((2 + k) % 4));
        end

        // A short pulse is ignored.
        repeat (20) step();
        press(3);
        wait_fs();
        wait_fs();
        check("bounce_pat", 32'(pattern), 32'd0);

        // Two valid presses in one frame give one increment.
        wait_fs();
        repeat (5) step();
        press(6);
        repeat (8) step();
        press(6);
        wait_fs();
        wait_fs();
        check("multi_pat", 32'(pattern), 32'd1);

        // Reach pattern 2, leave a press pending, then reset mid-line.
        repeat (10) step();
        press(8);
        wait_fs();
        wait_fs();
        check("pat_two", 32'(pattern), 32'd2);
        wait_fs();
        repeat (3) step();
        press(8);
        repeat (5) step();
        check("pre_rst_blank", 32'(blank_b), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_pat", 32'(pattern), 32'd0);
        check("rst_mid_rgb", 32'({r, g, b}), 32'd0);
        check("rst_mid_blank", 32'(blank_b), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (3 * HT * VT) step();
        check("post_rst_pat", 32'(pattern), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
